// File: rtl/vdp_cpu_port.sv
// CPU-facing port of a video display processor: two-byte control writes,
// auto-incrementing VRAM data port with a write FIFO and one-byte read-ahead,
// status register with sticky event flags, and a single-outstanding VRAM
// request handshake.
module vdp_cpu_port #(
   parameter int VRAM_SIZE  = 16384,
   parameter int NUM_REGS   = 8,
   parameter int FIFO_DEPTH = 4,
   localparam int AW = $clog2(VRAM_SIZE),
   localparam int RW = $clog2(NUM_REGS)
) (
   input  logic          pxclk,
   input  logic          reset_n,
   input  logic          wr_tick,
   input  logic          rd_tick,
   input  logic          mode,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          reg_wr,
   output logic [RW-1:0] reg_num,
   output logic [7:0]    reg_data,
   output logic          vram_req,
   output logic          vram_we,
   output logic [AW-1:0] vram_addr,
   output logic [7:0]    vram_wdata,
   input  logic          vram_ack,
   input  logic [7:0]    vram_rdata,
   input  logic          frame_tick,
   input  logic          spr5_tick,
   input  logic [4:0]    spr5_num,
   input  logic          coll_tick,
   input  logic          ie,
   output logic          irq,
   output logic          overrun,
   output logic          busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;
   state_t state_reg, state_next;

   logic [AW-1:0] addr_reg, pend_addr_reg, vram_addr_reg;
   logic [7:0]    latch_reg, rbuf_reg, vram_wdata_reg;
   logic          phase_reg, pend_reg, stale_reg, overrun_reg;
   logic          f_reg, s5_reg, c_reg;
   logic [4:0]    fifth_reg;
   logic          reg_wr_reg;
   logic [RW-1:0] reg_num_reg;
   logic [7:0]    reg_data_reg;

   logic [AW+7:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;

   // decoded CPU strobes; a simultaneous read is dropped in favour of the write
   logic          data_wr, ctl_wr, data_rd, ctl_rd;
   logic          reg_cmd, addr_load, pf_load;
   logic          fifo_full, fifo_empty, push, pop;
   logic          start_wr, start_rd, rd_done, wr_hit;
   logic [AW-1:0] addr_inc, ctl_addr;
   logic [13:0]   ctl_addr14;

   assign data_wr    = wr_tick & ~mode;
   assign ctl_wr     = wr_tick & mode;
   assign data_rd    = rd_tick & ~wr_tick & ~mode;
   assign ctl_rd     = rd_tick & ~wr_tick & mode;
   assign reg_cmd    = ctl_wr & phase_reg & din[7];
   assign addr_load  = ctl_wr & phase_reg & ~din[7];
   assign pf_load    = addr_load & ~din[6];
   assign ctl_addr14 = {din[5:0], latch_reg};
   assign ctl_addr   = AW'(ctl_addr14);
   assign addr_inc   = addr_reg + 1'b1;
   assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign pop        = (state_reg == WR) & vram_ack;
   assign push       = data_wr & (~fifo_full | pop);
   assign rd_done    = (state_reg == RD) & vram_ack;
   // a CPU write to the address currently being fetched makes that fetch stale
   assign wr_hit     = data_wr & (state_reg == RD) & (addr_reg == vram_addr_reg);

   assign dout       = mode ? {f_reg, s5_reg, c_reg, fifth_reg} : rbuf_reg;
   assign irq        = ie & f_reg;
   assign overrun    = overrun_reg;
   assign busy       = ~fifo_empty | (state_reg != IDLE);
   assign reg_wr     = reg_wr_reg;
   assign reg_num    = reg_num_reg;
   assign reg_data   = reg_data_reg;
   assign vram_addr  = vram_addr_reg;
   assign vram_wdata = vram_wdata_reg;

   // FSM state register
   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // next state and request outputs; queued writes always win over a prefetch
   always_comb begin
      state_next = state_reg;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      vram_req   = 1'b0;
      vram_we    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = WR;
               start_wr   = 1'b1;
            end else if (pend_reg) begin
               state_next = RD;
               start_rd   = 1'b1;
            end
         end
         WR: begin
            vram_req = 1'b1;
            vram_we  = 1'b1;
            if (vram_ack) state_next = IDLE;
         end
         RD: begin
            vram_req = 1'b1;
            if (vram_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // write FIFO storage
   always_ff @(posedge pxclk) begin
      if (push) fifo_mem[wr_ptr_reg] <= {addr_reg, din};
   end

   // FIFO pointers and the request address/data held stable for a whole request
   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         vram_addr_reg  <= '0;
         vram_wdata_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (start_wr)      {vram_addr_reg, vram_wdata_reg} <= fifo_mem[rd_ptr_reg];
         else if (start_rd) vram_addr_reg <= pend_addr_reg;
      end
   end

   // CPU side: address pointer, two-byte latch, prefetch slot, read buffer
   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) begin
         addr_reg      <= '0;
         latch_reg     <= '0;
         phase_reg     <= 1'b0;
         pend_reg      <= 1'b0;
         pend_addr_reg <= '0;
         rbuf_reg      <= '0;
         stale_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
         reg_wr_reg    <= 1'b0;
         reg_num_reg   <= '0;
         reg_data_reg  <= '0;
      end else begin
         if (ctl_wr)                          phase_reg <= ~phase_reg;
         else if (data_wr | data_rd | ctl_rd) phase_reg <= 1'b0;
         if (ctl_wr & ~phase_reg) latch_reg <= din;

         if (addr_load)              addr_reg <= ctl_addr;
         else if (data_wr | data_rd) addr_reg <= addr_inc;

         // issuing empties the slot; a request in the same cycle refills it
         if (start_rd) pend_reg <= 1'b0;
         if (pf_load) begin
            pend_reg      <= 1'b1;
            pend_addr_reg <= ctl_addr;
         end else if (data_rd) begin
            pend_reg      <= 1'b1;
            pend_addr_reg <= addr_inc;
         end

         if (start_rd)    stale_reg <= 1'b0;
         else if (wr_hit) stale_reg <= 1'b1;
         if (rd_done & ~stale_reg) rbuf_reg <= vram_rdata;
         if (data_wr)              rbuf_reg <= din;

         if (data_wr & ~push) overrun_reg <= 1'b1;

         reg_wr_reg <= reg_cmd;
         if (reg_cmd) begin
            reg_num_reg  <= din[RW-1:0];
            reg_data_reg <= latch_reg;
         end
      end
   end

   // status flags: events win over the clear of a coincident status read
   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) begin
         f_reg     <= 1'b0;
         s5_reg    <= 1'b0;
         c_reg     <= 1'b0;
         fifth_reg <= '0;
      end else begin
         f_reg  <= frame_tick | (f_reg & ~ctl_rd);
         c_reg  <= coll_tick | (c_reg & ~ctl_rd);
         s5_reg <= spr5_tick | (s5_reg & ~ctl_rd);
         if (spr5_tick & ~s5_reg) fifth_reg <= spr5_num;
      end
   end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: a table of single-cycle CPU vectors for the
// register/status path, plus hand sequences for VRAM read-ahead, FIFO overflow,
// address wrap and reset during a request. A small VRAM model answers requests.
module tb_vdp_cpu_port;

   logic        pxclk = 1'b0;
   logic        reset_n;
   logic        wr_tick, rd_tick, mode;
   logic [7:0]  din, dout;
   logic        reg_wr;
   logic [2:0]  reg_num;
   logic [7:0]  reg_data;
   logic        vram_req, vram_we, vram_ack;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata, vram_rdata;
   logic        frame_tick, spr5_tick, coll_tick, ie;
   logic [4:0]  spr5_num;
   logic        irq, overrun, busy;

   vdp_cpu_port dut (
      .pxclk(pxclk), .reset_n(reset_n), .wr_tick(wr_tick), .rd_tick(rd_tick),
      .mode(mode), .din(din), .dout(dout), .reg_wr(reg_wr), .reg_num(reg_num),
      .reg_data(reg_data), .vram_req(vram_req), .vram_we(vram_we),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
      .vram_rdata(vram_rdata), .frame_tick(frame_tick), .spr5_tick(spr5_tick),
      .spr5_num(spr5_num), .coll_tick(coll_tick), .ie(ie), .irq(irq),
      .overrun(overrun), .busy(busy)
   );

   always #5 pxclk = ~pxclk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic we;
      logic [13:0] addr;
      logic [7:0] data;
   } acc_t;
   acc_t acc_q[$];
   logic [7:0] vmem [16384];
   logic ack_hold = 1'b0;
   int   ack_lat  = 3;
   int   lat_cnt;

   // VRAM model: acknowledges after ack_lat request cycles, logs every access
   initial begin
      vram_ack   = 1'b0;
      vram_rdata = 8'h00;
      lat_cnt    = 0;
      forever begin
         @(posedge pxclk);
         #1;
         if (!reset_n || vram_ack) begin
            vram_ack = 1'b0;
            lat_cnt  = 0;
         end else if (vram_req && !ack_hold) begin
            lat_cnt++;
            if (lat_cnt >= ack_lat) begin
               vram_ack = 1'b1;
               acc_q.push_back('{vram_we, vram_addr, vram_we ? vram_wdata : vmem[vram_addr]});
               if (vram_we) vmem[vram_addr] = vram_wdata;
               else         vram_rdata = vmem[vram_addr];
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // advance one clock, land 1 time unit after the edge, drop the pulses
   task automatic step();
      @(posedge pxclk);
      #1;
      wr_tick = 1'b0; rd_tick = 1'b0;
      frame_tick = 1'b0; coll_tick = 1'b0; spr5_tick = 1'b0;
   endtask

   task automatic ctl_write(input logic [7:0] d);
      wr_tick = 1'b1; mode = 1'b1; din = d;
      step();
      $display("ctl_write %02h", d);
   endtask

   task automatic data_write(input logic [7:0] d);
      wr_tick = 1'b1; mode = 1'b0; din = d;
      step();
      $display("data_write %02h", d);
   endtask

   task automatic data_read(input logic [7:0] exp, input string nm);
      rd_tick = 1'b1; mode = 1'b0;
      #2;
      check(nm, dout, exp);
      $display("data_read dout=%02h expect=%02h", dout, exp);
      step();
   endtask

   task automatic ctl_read(input logic [7:0] exp, input string nm);
      rd_tick = 1'b1; mode = 1'b1;
      #2;
      check(nm, dout, exp);
      $display("ctl_read dout=%02h expect=%02h", dout, exp);
      step();
   endtask

   task automatic wait_idle(input string nm);
      int n;
      repeat (2) step();
      n = 0;
      while (busy && n < 300) begin
         step();
         n++;
      end
      check(nm, busy, 1'b0);
   endtask

   typedef struct {
      logic wr, rd, md;
      logic [7:0] din;
      logic fr, co, s5;
      logic [4:0] sn;
      logic ie;
      logic ckd;
      logic [7:0] dout;
      logic irq;
      logic rw;
      logic [2:0] rn;
      logic [7:0] rdat;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(logic wr, logic rd, logic md, logic [7:0] d,
                               logic fr, logic co, logic s5, logic [4:0] sn,
                               logic iev, logic ckd, logic [7:0] dv, logic irqv,
                               logic rw, logic [2:0] rn, logic [7:0] rdv);
      vec_t v;
      v.wr = wr; v.rd = rd; v.md = md; v.din = d;
      v.fr = fr; v.co = co; v.s5 = s5; v.sn = sn; v.ie = iev;
      v.ckd = ckd; v.dout = dv; v.irq = irqv; v.rw = rw; v.rn = rn; v.rdat = rdv;
      return v;
   endfunction

   initial begin
      int base;
      vec_t v;
      for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
      vmem[14'h1234] = 8'hA1; vmem[14'h1235] = 8'hB2;
      vmem[14'h1236] = 8'hC3; vmem[14'h1237] = 8'hD4;

      //            wr rd md din    fr co s5 sn     ie ckd dout   irq rw rn reg_data
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 0, 1,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(1,0,1,8'h5A, 0,0,0,5'h00, 0, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(1,0,1,8'h87, 0,0,0,5'h00, 0, 0,8'h00, 0, 1,7,8'h5A));
      vecs.push_back(mk(0,0,0,8'h00, 0,0,0,5'h00, 0, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00, 1,0,0,5'h00, 1, 0,8'h00, 1, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h80, 0, 0,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00, 0,1,0,5'h00, 1, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00, 0,0,1,5'h13, 1, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00, 0,0,1,5'h05, 1, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h73, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h13, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 1,0,0,5'h00, 1, 1,8'h13, 1, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h93, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,1,0,5'h00, 1, 1,8'h13, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h33, 0, 0,0,8'h00));
      vecs.push_back(mk(1,0,1,8'h11, 0,0,0,5'h00, 1, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h13, 0, 0,0,8'h00));
      vecs.push_back(mk(1,0,1,8'h22, 0,0,0,5'h00, 1, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(1,0,1,8'h81, 0,0,0,5'h00, 1, 0,8'h00, 0, 1,1,8'h22));
      vecs.push_back(mk(1,0,1,8'h44, 0,0,0,5'h00, 1, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(1,1,1,8'h83, 0,0,0,5'h00, 1, 0,8'h00, 0, 1,3,8'h44));
      vecs.push_back(mk(0,0,0,8'h00, 1,0,0,5'h00, 0, 0,8'h00, 0, 0,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00, 0,0,0,5'h00, 1, 0,8'h00, 1, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h93, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,1,5'h0A, 1, 1,8'h13, 0, 0,0,8'h00));
      vecs.push_back(mk(0,1,1,8'h00, 0,0,0,5'h00, 1, 1,8'h4A, 0, 0,0,8'h00));

      wr_tick = 0; rd_tick = 0; mode = 0; din = 0;
      frame_tick = 0; coll_tick = 0; spr5_tick = 0; spr5_num = 0; ie = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge pxclk);
      #1 reset_n = 1'b1;
      step();

      check("reset_busy", busy, 1'b0);
      check("reset_req", vram_req, 1'b0);
      check("reset_irq", irq, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      check("reset_reg_wr", reg_wr, 1'b0);

      // register and status vectors, one CPU cycle each
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         wr_tick = v.wr; rd_tick = v.rd; mode = v.md; din = v.din;
         frame_tick = v.fr; coll_tick = v.co; spr5_tick = v.s5; spr5_num = v.sn; ie = v.ie;
         #2;
         if (v.ckd) check($sformatf("v%0d_dout", i), dout, v.dout);
         step();
         check($sformatf("v%0d_irq", i), irq, v.irq);
         check($sformatf("v%0d_reg_wr", i), reg_wr, v.rw);
         if (v.rw) begin
            check($sformatf("v%0d_reg_num", i), reg_num, v.rn);
            check($sformatf("v%0d_reg_data", i), reg_data, v.rdat);
         end
         $display("vector %0d wr=%0b rd=%0b mode=%0b din=%02h dout=%02h irq=%0b reg_wr=%0b",
                  i, v.wr, v.rd, v.md, v.din, dout, irq, reg_wr);
      end
      check("regs_no_vram_traffic", acc_q.size(), 0);

      // read setup with prefetch, three reads
      base = acc_q.size();
      ctl_write(8'h34);
      ctl_write(8'h12);
      wait_idle("rd_setup_idle");
      data_read(8'hA1, "rd0_dout");
      wait_idle("rd0_idle");
      data_read(8'hB2, "rd1_dout");
      wait_idle("rd1_idle");
      data_read(8'hC3, "rd2_dout");
      wait_idle("rd2_idle");
      check("rd_count", acc_q.size(), base + 4);
      if (acc_q.size() >= base + 3)
         for (int i = 0; i < 3; i++) begin
            check($sformatf("rd%0d_addr", i), acc_q[base+i].addr, 14'h1234 + 14'(i));
            check($sformatf("rd%0d_we", i), acc_q[base+i].we, 1'b0);
         end

      // write burst against a stalled VRAM: fifth byte overflows
      ack_hold = 1'b1;
      base = acc_q.size();
      ctl_write(8'h00);
      ctl_write(8'h7F);
      for (int i = 0; i < 5; i++) data_write(8'h10 + 8'(i));
      check("burst_overrun", overrun, 1'b1);
      check("burst_busy", busy, 1'b1);
      check("burst_stalled", acc_q.size(), base);
      ack_hold = 1'b0;
      wait_idle("burst_drain_idle");
      data_write(8'h15);
      wait_idle("burst_post_idle");
      check("burst_count", acc_q.size(), base + 5);
      if (acc_q.size() >= base + 5) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("burst%0d_addr", i), acc_q[base+i].addr, 14'h3F00 + 14'(i));
            check($sformatf("burst%0d_data", i), acc_q[base+i].data, 8'h10 + 8'(i));
            check($sformatf("burst%0d_we", i), acc_q[base+i].we, 1'b1);
         end
         check("burst_next_addr", acc_q[base+4].addr, 14'h3F05);
         check("burst_next_data", acc_q[base+4].data, 8'h15);
      end

      // address wrap, then read back the last byte written before the wrap
      base = acc_q.size();
      ctl_write(8'hFF);
      ctl_write(8'h7F);
      data_write(8'hAA);
      data_write(8'hBB);
      wait_idle("wrap_idle");
      check("wrap_count", acc_q.size(), base + 2);
      if (acc_q.size() >= base + 2) begin
         check("wrap_addr0", acc_q[base].addr, 14'h3FFF);
         check("wrap_addr1", acc_q[base+1].addr, 14'h0000);
         check("wrap_data1", acc_q[base+1].data, 8'hBB);
      end
      ctl_write(8'hFF);
      ctl_write(8'h3F);
      wait_idle("wrap_rd_idle");
      data_read(8'hAA, "wrap_readback");
      wait_idle("wrap_rd2_idle");

      // reset while a write request is outstanding
      ie = 1'b1;
      frame_tick = 1'b1;
      step();
      check("pre_reset_irq", irq, 1'b1);
      ack_hold = 1'b1;
      base = acc_q.size();
      ctl_write(8'h00);
      ctl_write(8'h50);
      data_write(8'h66);
      begin
         int n = 0;
         while (!vram_req && n < 20) begin
            step();
            n++;
         end
      end
      check("mid_req_high", vram_req, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_reset_req", vram_req, 1'b0);
      check("mid_reset_irq", irq, 1'b0);
      $display("reset asserted mid-request vram_req=%0b", vram_req);
      @(posedge pxclk);
      #1 reset_n = 1'b1;
      ack_hold = 1'b0;
      repeat (3) step();
      check("post_reset_busy", busy, 1'b0);
      check("post_reset_overrun", overrun, 1'b0);
      check("post_reset_no_access", acc_q.size(), base);
      ctl_read(8'h00, "post_reset_status");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 Parameters: VRAM_SIZE, default 16384, VRAM bytes (power of 2, AW=$clog2(VRAM_SIZE)); NUM_REGS, default 8, control registers (power of 2, max 64, RW=$clog2(NUM_REGS)); FIFO_DEPTH, default 4, write-FIFO entries (power of 2, >=2).
REQ-002 Ports: pxclk in 1 pixel clock; reset_n in 1 async active-low reset; wr_tick in 1 CPU write pulse; rd_tick in 1 CPU read pulse; mode in 1 port select, 0=data and 1=control; din in 8 CPU write data; dout out 8 CPU read data, valid while rd_tick is high.
REQ-003 Register-side ports: reg_wr out 1 register write pulse; reg_num out RW register index; reg_data out 8 register value.
REQ-004 VRAM-side ports: vram_req out 1 access request; vram_we out 1 1=write; vram_addr out AW; vram_wdata out 8; vram_ack in 1 one-cycle completion; vram_rdata in 8, valid with vram_ack.
REQ-005 Status and interrupt ports: frame_tick in 1 end-of-frame pulse; spr5_tick in 1 fifth-sprite event; spr5_num in 5; coll_tick in 1 sprite collision event; ie in 1 interrupt enable; irq out 1; overrun out 1 sticky FIFO-overflow flag; busy out 1, high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-006 Control write, first byte: stores din in latch and sets the phase flag.
REQ-007 Control write, second byte (phase flag set): clears the phase flag, then decodes din.
- din[7]=1: pulses reg_wr for 1 cycle, reg_num=din[RW-1:0], reg_data=latch.
- din[7:6]=01: addr={din[5:0],latch}[AW-1:0], no prefetch.
- din[7:6]=00: same address load, then queues a prefetch read.
REQ-008 A data-port access or any control read clears the phase flag.
REQ-009 Data write: pushes {addr,din} into the write FIFO, copies din into the read buffer, and increments addr modulo VRAM_SIZE.
REQ-010 Data write with FIFO full: the byte is dropped, overrun is set, and addr still increments.
REQ-011 Data read: dout=read buffer combinationally, then addr increments modulo VRAM_SIZE and a prefetch of the new addr is queued.
REQ-012 Prefetch storage: a single prefetch slot; a newer prefetch request replaces an unissued one.
REQ-013 Control read: dout={F,5S,C,fifth_num[4:0]}. After the read, F, 5S and C clear; fifth_num holds its value.
REQ-014 Status flag setting:
- frame_tick sets F.
- coll_tick sets C.
- spr5_tick sets 5S and loads fifth_num, only while 5S=0.
REQ-015 An event coinciding with the status read that clears its flag: the flag stays set, and the read returns the pre-event value.
REQ-016 irq = ie & F, combinational.
REQ-017 FSM states:
- IDLE -> WR when the FIFO is non-empty.
- IDLE -> RD when the FIFO is empty and a prefetch is pending.
- WR -> IDLE on vram_ack; pops the FIFO.
- RD -> IDLE on vram_ack; loads the read buffer with vram_rdata and clears pending, unless a newer prefetch arrived during RD, which stays pending.
REQ-018 Ordering: pending writes always issue before a prefetch, so a read never returns data older than a preceding write to the same address.
REQ-019 Request handshake: vram_req rises on entry to WR or RD and stays high with vram_we, vram_addr and vram_wdata stable until vram_ack. It is low the cycle after ack, and at least 1 IDLE cycle separates requests.
REQ-020 vram_ack outside WR/RD is ignored.
REQ-021 A CPU data write during RD that hits the prefetch address goes to the FIFO; the later vram_rdata load is superseded by the REQ-009 copy. The read buffer keeps the written byte.
REQ-022 Simultaneous push and pop on a full FIFO: the push is accepted.
REQ-023 wr_tick and rd_tick high in the same cycle: wr_tick is processed and rd_tick is ignored.

Reset
REQ-024 reset_n low asynchronously clears the following:
- FSM to IDLE, FIFO empty, prefetch pending 0.
- addr, latch, phase flag, read buffer, F, 5S, C, fifth_num, overrun all 0.
- vram_req, reg_wr and irq go to 0 immediately, including mid-request.
REQ-025 The first access after reset_n deasserts behaves as from a fresh power-up; an in-flight vram_ack is ignored.

Verification
REQ-026 Register write: control writes 0x5A then 0x87 -> reg_wr 1-cycle pulse, reg_num=7, reg_data=0x5A; no VRAM traffic.
REQ-027 Read setup: control 0x34 then 0x12, then 3 data reads with ack latency 3 -> reads occur at addresses 0x1234, 0x1235, 0x1236. First dout is the prefetched byte at 0x1234.
REQ-028 Write burst: write setup 0x00/0x7F, then 5 data writes with vram_ack held off and FIFO_DEPTH=4.
- 5th byte dropped, overrun=1.
- addr=0x3F05 after the 5 writes.
- On release, the FIFO drains in order to addresses 0x3F00-0x3F03.
REQ-029 Wrap: addr=VRAM_SIZE-1, data write -> next write targets 0x0000.
REQ-030 Status: frame_tick with ie=1 -> irq=1. Status read returns bit7=1 and irq drops. A frame_tick coincident with a later read leaves F=1.
REQ-031 Reset mid-request: reset_n pulled low during WR with vram_req=1 -> vram_req=0 the same cycle. After release, busy=0 and status reads 0x00.
